// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the MIPS immediate-extension stage.
package imm_ext_pkg;

   localparam int unsigned IMM_IN_W  = 16;
   localparam int unsigned IMM_OUT_W = 32;
   localparam int unsigned IMM_TAG_W = 5;

   typedef enum logic [1:0] {
      IMM_SEXT   = 2'd0,
      IMM_ZEXT   = 2'd1,
      IMM_UPPER  = 2'd2,
      IMM_BRANCH = 2'd3
   } imm_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset modes.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W  = IMM_IN_W,
   parameter int unsigned OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  imm,
   input  imm_mode_t        mode,
   output logic [OUT_W-1:0] data,
   output logic             neg
);

   logic [OUT_W-1:0] w_sext;

   assign w_sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      data = w_sext;
      neg  = 1'b0;
      case (mode)
         IMM_SEXT: begin
            data = w_sext;
            neg  = imm[IN_W-1];
         end
         IMM_ZEXT:  data = {{(OUT_W-IN_W){1'b0}}, imm};
         IMM_UPPER: data = {imm, {(OUT_W-IN_W){1'b0}}};
         IMM_BRANCH: begin
            // Word offset: the shift drops the two top sign copies.
            data = {w_sext[OUT_W-3:0], 2'b00};
            neg  = imm[IN_W-1];
         end
         default: begin
            data = w_sext;
            neg  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready handshake and flush.
// Define IMM_EXT_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module imm_extend_stage
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W  = IMM_IN_W,
   parameter int unsigned OUT_W = IMM_OUT_W,
   parameter int unsigned TAG_W = IMM_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  imm_mode_t        in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg
);

   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_stage: OUT_W must be at least IN_W+2");
   end

   logic [OUT_W-1:0] w_ext_data;
   logic             w_ext_neg;
   logic             w_acc;

   logic             r_valid;
   logic [OUT_W-1:0] r_data;
   logic [TAG_W-1:0] r_tag;
   logic             r_neg;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .data (w_ext_data),
      .neg  (w_ext_neg)
   );

   assign w_acc     = in_valid && in_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_tag   = r_tag;
   assign out_neg   = r_neg;

`ifdef IMM_EXT_SKID_EN
   logic             r_skid_valid;
   logic [OUT_W-1:0] r_skid_data;
   logic [TAG_W-1:0] r_skid_tag;
   logic             r_skid_neg;

   // No path from out_ready: readiness depends only on skid occupancy.
   assign in_ready = !r_skid_valid && !reset && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_tag        <= '0;
         r_neg        <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_tag   <= '0;
         r_skid_neg   <= 1'b0;
      end else if (flush) begin
         r_valid      <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
         if (out_ready) begin
            r_data       <= r_skid_data;
            r_tag        <= r_skid_tag;
            r_neg        <= r_skid_neg;
            r_skid_valid <= 1'b0;
         end
      end else if (!r_valid || out_ready) begin
         r_valid <= w_acc;
         if (w_acc) begin
            r_data <= w_ext_data;
            r_tag  <= in_tag;
            r_neg  <= w_ext_neg;
         end
      end else if (w_acc) begin
         r_skid_valid <= 1'b1;
         r_skid_data  <= w_ext_data;
         r_skid_tag   <= in_tag;
         r_skid_neg   <= w_ext_neg;
      end
   end
`else
   assign in_ready = (!r_valid || out_ready) && !reset && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tag   <= '0;
         r_neg   <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (!r_valid || out_ready) begin
         r_valid <= w_acc;
         if (w_acc) begin
            r_data <= w_ext_data;
            r_tag  <= in_tag;
            r_neg  <= w_ext_neg;
         end
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed, table-driven bench for imm_extend_stage (default and 8->16 builds).
module tb_imm_extend_stage;
   import imm_ext_pkg::*;

`ifdef IMM_EXT_SKID_EN
   localparam int EXP_ACC = 2;
`else
   localparam int EXP_ACC = 1;
`endif

   typedef struct {
      imm_mode_t   mode;
      logic [15:0] imm;
      logic [4:0]  tag;
      logic [31:0] exp_data;
      logic        exp_neg;
   } vec_t;

   typedef struct {
      imm_mode_t   mode;
      logic [7:0]  imm;
      logic [15:0] exp_data;
      logic        exp_neg;
   } vec8_t;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        in_valid, in_ready, out_valid, out_ready, out_neg;
   logic [15:0] in_imm;
   imm_mode_t   in_mode;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] out_data;

   logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_out_neg;
   logic [7:0]  p_in_imm;
   imm_mode_t   p_in_mode;
   logic [4:0]  p_in_tag, p_out_tag;
   logic [15:0] p_out_data;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t        vecs[6];
   vec8_t       vecs8[3];
   logic [4:0]  q_tag[$];
   logic [31:0] q_data[$];

   always #5 clk = ~clk;

   imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_neg(out_neg)
   );

   imm_extend_stage #(.IN_W(8), .OUT_W(16), .TAG_W(5)) u_dut8 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm),
      .in_mode(p_in_mode), .in_tag(p_in_tag), .out_valid(p_out_valid),
      .out_ready(p_out_ready), .out_data(p_out_data), .out_tag(p_out_tag),
      .out_neg(p_out_neg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] stream_imm(input int i);
      return 16'(i * 32'h2222);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s_imm;
      int          acc;

      vecs[0] = '{IMM_SEXT,   16'h0005, 5'd1, 32'h0000_0005, 1'b0};
      vecs[1] = '{IMM_SEXT,   16'hFFF9, 5'd2, 32'hFFFF_FFF9, 1'b1};
      vecs[2] = '{IMM_ZEXT,   16'hFFF9, 5'd3, 32'h0000_FFF9, 1'b0};
      vecs[3] = '{IMM_UPPER,  16'h1234, 5'd4, 32'h1234_0000, 1'b0};
      vecs[4] = '{IMM_BRANCH, 16'hFFFF, 5'd5, 32'hFFFF_FFFC, 1'b1};
      vecs[5] = '{IMM_BRANCH, 16'h0003, 5'd6, 32'h0000_000C, 1'b0};
      vecs8[0] = '{IMM_SEXT,   8'h80, 16'hFF80, 1'b1};
      vecs8[1] = '{IMM_UPPER,  8'h12, 16'h1200, 1'b0};
      vecs8[2] = '{IMM_BRANCH, 8'hFF, 16'hFFFC, 1'b1};

      reset = 1'b1; flush = 1'b0;
      in_valid = 1'b0; in_imm = '0; in_mode = IMM_SEXT; in_tag = '0; out_ready = 1'b1;
      p_in_valid = 1'b0; p_in_imm = '0; p_in_mode = IMM_SEXT; p_in_tag = '0;
      p_out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_neg", 32'(out_neg), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Mode vectors, 1-cycle gap between entries
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_mode = vecs[i].mode; in_imm = vecs[i].imm; in_tag = vecs[i].tag;
         @(negedge clk);
         check("mode_valid", 32'(out_valid), 32'd1);
         check("mode_data", out_data, vecs[i].exp_data);
         check("mode_neg", 32'(out_neg), 32'(vecs[i].exp_neg));
         check("mode_tag", 32'(out_tag), 32'(vecs[i].tag));
         in_valid = 1'b0;
         @(negedge clk);
         check("mode_gap_valid", 32'(out_valid), 32'd0);
      end

      // Streaming: 8 back-to-back SEXT entries
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            s_imm = stream_imm(i - 1);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_tag", 32'(out_tag), 32'(i - 1));
            check("stream_data", out_data, {{16{s_imm[15]}}, s_imm});
         end
         if (i < 8) begin
            in_valid = 1'b1; in_mode = IMM_SEXT; in_imm = stream_imm(i); in_tag = 5'(i);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("stream_end_valid", 32'(out_valid), 32'd0);

      // Backpressure: out_ready low for 4 cycles with in_valid high
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_tag", 32'(out_tag), 32'd20);
            check("bp_hold_data", out_data, 32'h0000_A000);
         end
         out_ready = 1'b0; in_valid = 1'b1; in_mode = IMM_ZEXT;
         in_imm = 16'hA000 + 16'(acc); in_tag = 5'(20 + acc);
         #1;
         if (in_ready) begin
            q_tag.push_back(in_tag);
            q_data.push_back({16'h0000, in_imm});
            acc++;
         end
      end
      check("bp_accept_count", 32'(acc), 32'(EXP_ACC));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         if (out_valid && q_tag.size() > 0) begin
            check("bp_drain_tag", 32'(out_tag), 32'(q_tag.pop_front()));
            check("bp_drain_data", out_data, q_data.pop_front());
         end else begin
            check("bp_no_extra", 32'(out_valid), 32'd0);
         end
      end
      check("bp_all_drained", 32'(q_tag.size()), 32'd0);

      // Flush with entries held and a simultaneous input
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_mode = IMM_SEXT; in_imm = 16'h0030; in_tag = 5'd30;
      @(negedge clk);
      in_imm = 16'h0031; in_tag = 5'd31;
      @(negedge clk);
      flush = 1'b1; in_imm = 16'h0009; in_tag = 5'd9;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      check("flush_held_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("flush_no_stale", 32'(out_valid), 32'd0);
      end

      // Reset mid-stream
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_mode = IMM_SEXT; in_imm = 16'h8001; in_tag = 5'd17;
      @(negedge clk);
      check("mid_pre_valid", 32'(out_valid), 32'd1);
      check("mid_pre_data", out_data, 32'hFFFF_8001);
      reset = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", out_data, 32'd0);
      check("mid_rst_tag", 32'(out_tag), 32'd0);
      check("mid_rst_neg", 32'(out_neg), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("mid_post_in_ready", 32'(in_ready), 32'd1);
      check("mid_post_valid", 32'(out_valid), 32'd0);

      // 8 -> 16 bit build
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         p_in_valid = 1'b1; p_in_mode = vecs8[i].mode; p_in_imm = vecs8[i].imm;
         p_in_tag = 5'(i + 1);
         @(negedge clk);
         p_in_valid = 1'b0;
         check("w8_valid", 32'(p_out_valid), 32'd1);
         check("w8_data", 32'(p_out_data), 32'(vecs8[i].exp_data));
         check("w8_neg", 32'(p_out_neg), 32'(vecs8[i].exp_neg));
         check("w8_tag", 32'(p_out_tag), 32'(i + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Pipelined, parametrised immediate-extension stage for the MIPS decode path. It accepts a raw instruction immediate with an extension mode and returns the operand-width result one cycle later over a valid/ready handshake. It supports sign, zero, upper (LUI) and branch-offset extension, plus backpressure and flush. It sits between the instruction decoder and the ID/EX operand mux.

## Interface
Parameters:
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W+2, otherwise elaboration fails via `$error`
- TAG_W, 5, width of the sideband tag (destination register) carried alongside the data

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush; drops all held entries
- in_valid  in  1  input entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  extension mode (imm_mode_t)
- in_tag  in  TAG_W  sideband tag, passed through unchanged
- out_valid  out  1  output entry present
- out_ready  in  1  consumer accepts the output this cycle
- out_data  out  OUT_W  extended result
- out_tag  out  TAG_W  tag of the output entry
- out_neg  out  1  MSB of the source immediate when mode is SEXT or BRANCH; 0 otherwise

## Operation
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Mode SEXT (0): out_data is in_imm sign-extended to OUT_W.
- Mode ZEXT (1): out_data is in_imm zero-extended.
- Mode UPPER (2): out_data is in_imm << (OUT_W-IN_W), with the low bits zero.
- Mode BRANCH (3): out_data is sign-extend(in_imm) << 2, truncated to OUT_W.
- Ordering is strict FIFO. No entry is duplicated or dropped, except on flush or reset.
- While out_valid=1 and out_ready=0, out_data, out_tag and out_neg are held stable.
- Flush clears all entries at the next edge, so out_valid=0 on the following cycle.
  - While flush=1, in_ready=0 and any in_valid is ignored.
  - Flush takes priority over any simultaneous transfer.
- Reset has the same effect as flush. It also clears out_data, out_tag and out_neg to 0.

## Timing
- Latency: an entry accepted at edge N is presented on out_valid/out_data in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle while out_ready=1.
- Reset values:
  - out_valid=0, out_data=0, out_tag=0, out_neg=0.
  - in_ready=0 while reset=1.
  - in_ready=1 in the first cycle after reset deasserts.
- Accept and drain in the same cycle is allowed. The new entry replaces the drained one with no bubble.
- Reset asserted mid-stream: all entries are lost. No output transfer is reported for the reset cycle.
- in_ready behaviour depends on the configuration below.

## Configuration
- Macro IMM_EXT_SKID_EN.
- Defined: a 2-entry skid buffer (main register plus skid register).
  - in_ready = !skid_valid, driven from a register only, so it has no combinational path from out_ready.
  - An entry accepted while the main register is stalled goes into the skid register.
  - The skid entry moves to main when main drains.
  - With 2 entries held, in_ready=0.
- Undefined: a single output register.
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Capacity is 1 entry.
- Both builds have identical data results, ordering and 1-cycle latency.

## Structure
- Package imm_ext_pkg holds:
  - imm_mode_t, a 2-bit enum: IMM_SEXT, IMM_ZEXT, IMM_UPPER, IMM_BRANCH
  - the default width localparams
- Sub-module imm_ext_core: a purely combinational extender, parametrised by IN_W and OUT_W, with inputs imm and mode and outputs data and neg.
- imm_extend_stage instantiates imm_ext_core once on the input side. Registers store already-extended data.

## Test plan
- Mode tests, each with out_ready=1 and a 1-cycle gap between inputs:
  - SEXT 0x0005 -> 0x00000005, neg=0
  - SEXT 0xFFF9 -> 0xFFFFFFF9, neg=1
  - ZEXT 0xFFF9 -> 0x0000FFF9, neg=0
  - UPPER 0x1234 -> 0x12340000
  - BRANCH 0xFFFF -> 0xFFFFFFFC, neg=1
  - BRANCH 0x0003 -> 0x0000000C
- Streaming: 8 back-to-back SEXT entries with tags 0-7 and out_ready=1 -> 8 consecutive outputs, in order, each 1 cycle after its input.
- Backpressure:
  - Hold out_ready=0 for 4 cycles while in_valid=1, then release.
  - The output is held stable throughout.
  - Skid build: exactly 2 entries are accepted, then in_ready=0. Non-skid build: exactly 1 entry is accepted.
  - After release, entries drain in order with no loss.
- Flush: with 2 entries held, assert flush together with in_valid -> out_valid=0 next cycle, the flushed-cycle input is not accepted, and no stale data appears afterwards.
- Reset mid-stream: assert reset with out_valid=1 -> the next cycle shows out_valid=0, out_data=0 and out_tag=0, and in_ready=1 in the first cycle after release.
- Parameter build with IN_W=8, OUT_W=16: SEXT 0x80 -> 0xFF80, UPPER 0x12 -> 0x1200, BRANCH 0xFF -> 0xFFFC.
